// File: rtl/xalu_pkg.sv
// Shared op-code and state encodings for the nibble-serial ALU sequencer.
package xalu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_XOR   = 3'd3,
    OP_PASSA = 3'd4,
    OP_PASSB = 3'd5,
    OP_SHR   = 3'd6,
    OP_SHL   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/xalu_nibble_seq_if.sv
// Bundle of signals between the sequencer and the external 4-bit ALU slice.
interface xalu_nibble_seq_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_f;
  logic       alu_ci_right;
  logic       alu_ci_left;
  logic       alu_com;
  logic [3:0] alu_d;
  logic       alu_co_left;
  logic       alu_co_right;

  modport master (
    output alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left, alu_com,
    input  alu_d, alu_co_left, alu_co_right
  );

  modport slave (
    input  alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left, alu_com,
    output alu_d, alu_co_left, alu_co_right
  );
endinterface

// File: rtl/xalu_nibble_seq.sv
// Sequences a W-bit ALU operation through an external 4-bit slice, one nibble
// per clock, chaining the carry/shift bit between nibbles.
module xalu_nibble_seq
  import xalu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 com,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_f,
  output logic                 alu_ci_right,
  output logic                 alu_ci_left,
  output logic                 alu_com,
  input  logic [3:0]           alu_d,
  input  logic                 alu_co_left,
  input  logic                 alu_co_right
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_e        state, state_nxt;
  op_e           op_q;
  logic          com_q;
  logic [W-1:0]  a_q, b_q, result_q, result_nxt;
  logic [IW-1:0] idx;
  logic          carry_q, carry_nxt;
  logic          cout_q, zero_q;
  logic          accept, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_f        = '0;
    alu_ci_right = 1'b0;
    alu_ci_left  = 1'b0;
    alu_com      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy         = 1'b1;
        alu_a        = a_q[{idx, 2'b00} +: 4];
        alu_b        = b_q[{idx, 2'b00} +: 4];
        alu_f        = op_q;
        alu_com      = com_q;
        // carry_q is seeded with cin on accept, so the first nibble sees cin
        alu_ci_right = (op_q == OP_ADD || op_q == OP_SHL) ? carry_q : 1'b0;
        alu_ci_left  = (op_q == OP_SHR) ? carry_q : 1'b0;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    last       = (op_q == OP_SHR) ? (idx == '0) : (idx == LAST);
    result_nxt = result_q;
    result_nxt[{idx, 2'b00} +: 4] = alu_d;
    case (op_q)
      OP_ADD, OP_SHL: carry_nxt = alu_co_left;
      OP_SHR:         carry_nxt = alu_co_right;
      default:        carry_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      com_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx      <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      op_q     <= op_e'(op);
      com_q    <= com;
      a_q      <= a;
      b_q      <= b;
      result_q <= '0;
      idx      <= (op_e'(op) == OP_SHR) ? LAST : '0;
      carry_q  <= cin;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (state == ST_RUN) begin
      result_q <= result_nxt;
      carry_q  <= carry_nxt;
      idx      <= (op_q == OP_SHR) ? idx - 1'b1 : idx + 1'b1;
      if (last) begin
        cout_q <= carry_nxt;
        zero_q <= (result_nxt == '0);
      end
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Scoreboard bench for xalu_nibble_seq with a behavioural 4-bit ALU slice.
module tb_xalu_nibble_seq;
  import xalu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic        com;
  logic        cin;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic        cout, zero;

  xalu_nibble_seq_if slc ();

  xalu_nibble_seq #(.NIBBLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .com          (com),
    .cin          (cin),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .cout         (cout),
    .zero         (zero),
    .alu_a        (slc.alu_a),
    .alu_b        (slc.alu_b),
    .alu_f        (slc.alu_f),
    .alu_ci_right (slc.alu_ci_right),
    .alu_ci_left  (slc.alu_ci_left),
    .alu_com      (slc.alu_com),
    .alu_d        (slc.alu_d),
    .alu_co_left  (slc.alu_co_left),
    .alu_co_right (slc.alu_co_right)
  );

  // Slice: ADD carries out of bit 3 to the left; SHR shifts bit 0 out to the right.
  logic [4:0] sum;
  logic [3:0] raw;
  always_comb begin
    sum = {1'b0, slc.alu_a} + {1'b0, slc.alu_b} + {4'b0, slc.alu_ci_right};
    raw = '0;
    slc.alu_co_left  = 1'b0;
    slc.alu_co_right = 1'b0;
    case (slc.alu_f)
      3'd0: begin raw = sum[3:0]; slc.alu_co_left = sum[4]; end
      3'd1: raw = slc.alu_a & slc.alu_b;
      3'd2: raw = slc.alu_a | slc.alu_b;
      3'd3: raw = slc.alu_a ^ slc.alu_b;
      3'd4: raw = slc.alu_a;
      3'd5: raw = slc.alu_b;
      3'd6: begin raw = {slc.alu_ci_left, slc.alu_a[3:1]}; slc.alu_co_right = slc.alu_a[0]; end
      default: begin raw = {slc.alu_a[2:0], slc.alu_ci_right}; slc.alu_co_left = slc.alu_a[3]; end
    endcase
    slc.alu_d = slc.alu_com ? ~raw : raw;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        z;
    int          cyc0;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {16'b0, result}, {16'b0, e.res});
        chk("cout", {31'b0, cout}, {31'b0, e.co});
        chk("zero", {31'b0, zero}, {31'b0, e.z});
        chk("done_latency", cyc - e.cyc0, 32'd4);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic c, input logic ci,
                       input logic [15:0] av, input logic [15:0] bv, input logic push,
                       input logic [15:0] er, input logic ec, input logic ez);
    exp_t e;
    @(negedge clk);
    op = o; com = c; cin = ci; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_run", {31'b0, busy}, 32'd1);
    if (push) begin
      e.res = er; e.co = ec; e.z = ez; e.cyc0 = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  int dc;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; com = 1'b0; cin = 1'b0; a = '0; b = '0;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_cout_zero", {30'b0, cout, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("idle_alu_out", {16'b0, slc.alu_a, slc.alu_b, slc.alu_f,
        slc.alu_ci_right, slc.alu_ci_left, slc.alu_com}, 32'd0);

    issue(OP_ADD,   1'b0, 1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0);
    wait_idle();
    issue(OP_ADD,   1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1);
    wait_idle();
    issue(OP_SHR,   1'b0, 1'b1, 16'h8001, 16'h0000, 1'b1, 16'hC000, 1'b1, 1'b0);
    wait_idle();
    issue(OP_SHL,   1'b0, 1'b0, 16'h8001, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b0);
    wait_idle();
    issue(OP_XOR,   1'b1, 1'b0, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    wait_idle();
    issue(OP_AND,   1'b0, 1'b1, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0);
    wait_idle();
    issue(OP_OR,    1'b0, 1'b0, 16'h0F00, 16'h00F0, 1'b1, 16'h0FF0, 1'b0, 1'b0);
    wait_idle();
    issue(OP_PASSB, 1'b1, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 16'hEDCB, 1'b0, 1'b0);
    wait_idle();
    issue(OP_ADD,   1'b0, 1'b1, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0);
    wait_idle();

    // start pulsed mid-RUN must be dropped
    dc = done_count;
    issue(OP_ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0);
    @(negedge clk);
    op = OP_PASSA; a = 16'hDEAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);
    chk("single_done", done_count - dc, 32'd1);
    chk("result_hold", {16'b0, result}, 32'h0100);

    // reset in the third RUN cycle aborts the operation
    issue(OP_ADD, 1'b0, 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_result", {16'b0, result}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    dc = done_count;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_count - dc, 32'd0);
    issue(OP_ADD, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
